door_lock_controller: RTL and testbench

- Keypad-driven electronic lock that produces the `locked` signal consumed by the `door` alarm block.
- Accepts BCD key entries and compares them against a parameterised PIN.
- Handles wrong-attempt lockout and auto-relock, which only counts down while the door is closed (`magnetic_sensor`=1).
- Sits between the keypad front-end and `door` in Smart_home_automation.

---
 rtl/door_lock_pkg.sv | 20 ++
 rtl/lock_timer.sv | 36 +++
 rtl/door_lock_controller.sv | 168 ++++++++++++++++
 tb/tb_door_lock_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/door_lock_pkg.sv
// Shared types and key decoding for the keypad door lock.
// Combinational definitions only; no timing or flow control.
package door_lock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ENTRY    = 3'd1,
      ST_CHECK    = 3'd2,
      ST_UNLOCKED = 3'd3,
      ST_LOCKOUT  = 3'd4
   } state_e;

   localparam logic [3:0] KEY_CLEAR = 4'hE;
   localparam logic [3:0] KEY_ENTER = 4'hF;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the lockout and relock paths; load wins over en.
// zero is combinational from the count register; the counter holds at 0.
module lock_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/door_lock_controller.sv
// Keypad lock FSM: PIN entry, one-cycle CHECK, unlocked relock timer and wrong-try lockout.
// Outputs registered: enter sampled at edge k gives locked/unlock_ok/bad_pin after edge k+1.
module door_lock_controller
   import door_lock_pkg::*;
#(
   parameter int                      PIN_DIGITS     = 4,
   parameter logic [4*PIN_DIGITS-1:0] PIN            = 16'h1234,
   parameter int                      MAX_TRIES      = 3,
   parameter int                      LOCKOUT_CYCLES = 64,
   parameter int                      RELOCK_CYCLES  = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       lock_cmd,
   input  logic       magnetic_sensor,
   output logic       locked,
   output logic       unlock_ok,
   output logic       bad_pin,
   output logic       lockout
);

   localparam int BUF_W   = 4 * PIN_DIGITS;
   localparam int CNT_W   = $clog2(PIN_DIGITS + 1);
   localparam int TRIES_W = $clog2(MAX_TRIES + 1);
   localparam int TMR_MAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX);

   state_e             state_q, state_d;
   logic [BUF_W-1:0]   entry_q, entry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [TRIES_W-1:0] tries_q, tries_d;
   logic               locked_q, locked_d;
   logic               unlock_ok_q, unlock_ok_d;
   logic               bad_pin_q, bad_pin_d;
   logic               lockout_q, lockout_d;

   logic               tmr_load;
   logic [TMR_W-1:0]   tmr_val;
   logic               tmr_en;
   logic               tmr_zero;
   logic               match;

   lock_timer #(.W(TMR_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (tmr_load),
      .load_value (tmr_val),
      .en         (tmr_en),
      .zero       (tmr_zero)
   );

   assign match = (cnt_q == CNT_W'(PIN_DIGITS)) && !ovf_q && (entry_q == PIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         entry_q     <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         tries_q     <= '0;
         locked_q    <= 1'b1;
         unlock_ok_q <= 1'b0;
         bad_pin_q   <= 1'b0;
         lockout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         entry_q     <= entry_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         tries_q     <= tries_d;
         locked_q    <= locked_d;
         unlock_ok_q <= unlock_ok_d;
         bad_pin_q   <= bad_pin_d;
         lockout_q   <= lockout_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      entry_d  = entry_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      tries_d  = tries_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_en   = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_ENTRY: begin
            if (key_valid) begin
               if (is_digit(key_code)) begin
                  entry_d = (entry_q << 4) | BUF_W'(key_code);
                  if (cnt_q < CNT_W'(PIN_DIGITS)) begin
                     cnt_d = cnt_q + 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
                  state_d = ST_ENTRY;
               end else if (key_code == KEY_CLEAR) begin
                  entry_d = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = ST_IDLE;
               end else if (key_code == KEY_ENTER) begin
                  state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            entry_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            if (match) begin
               state_d  = ST_UNLOCKED;
               tries_d  = '0;
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(RELOCK_CYCLES - 1);
            end else begin
               if (tries_q < TRIES_W'(MAX_TRIES)) begin
                  tries_d = tries_q + 1'b1;
               end
               if (tries_q == TRIES_W'(MAX_TRIES - 1)) begin
                  state_d  = ST_LOCKOUT;
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(LOCKOUT_CYCLES - 1);
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_UNLOCKED: begin
            // An open door keeps re-arming the timer and blocks lock_cmd.
            if (!magnetic_sensor) begin
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(RELOCK_CYCLES - 1);
            end else if (lock_cmd || tmr_zero) begin
               state_d = ST_IDLE;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_LOCKOUT: begin
            if (tmr_zero) begin
               state_d = ST_IDLE;
               tries_d = '0;
            end else begin
               tmr_en = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      locked_d    = (state_d != ST_UNLOCKED);
      lockout_d   = (state_d == ST_LOCKOUT);
      unlock_ok_d = (state_q == ST_CHECK) && match;
      bad_pin_d   = (state_q == ST_CHECK) && !match;
   end

   assign locked    = locked_q;
   assign unlock_ok = unlock_ok_q;
   assign bad_pin   = bad_pin_q;
   assign lockout   = lockout_q;

endmodule

// File: tb/tb_door_lock_controller.sv
// Scoreboarded bench for door_lock_controller: expected pulses queued at entry time, popped by a monitor.
module tb_door_lock_controller;

   logic       clk;
   logic       rst_n;
   logic       key_valid;
   logic [3:0] key_code;
   logic       lock_cmd;
   logic       magnetic_sensor;
   logic       locked;
   logic       unlock_ok;
   logic       bad_pin;
   logic       lockout;

   int checks   = 0;
   int failures = 0;
   int edges;

   localparam logic [1:0] EV_NONE   = 2'b00;
   localparam logic [1:0] EV_UNLOCK = 2'b10;
   localparam logic [1:0] EV_BAD    = 2'b01;

   logic [1:0] sb_q[$];

   door_lock_controller dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .key_valid       (key_valid),
      .key_code        (key_code),
      .lock_cmd        (lock_cmd),
      .magnetic_sensor (magnetic_sensor),
      .locked          (locked),
      .unlock_ok       (unlock_ok),
      .bad_pin         (bad_pin),
      .lockout         (lockout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Every unlock_ok/bad_pin pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && (unlock_ok || bad_pin)) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_pulse", {30'd0, unlock_ok, bad_pin}, 32'd0);
         end else begin
            chk("sb_pulse", {30'd0, unlock_ok, bad_pin}, {30'd0, sb_q.pop_front()});
         end
      end
   end

   task automatic press(input logic [3:0] c);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   // Keys packed MSB-first as nibbles; returns at the negedge after the output edge.
   task automatic enter_keys(input logic [31:0] keys, input int n, input logic [1:0] ev);
      if (ev != EV_NONE) sb_q.push_back(ev);
      for (int i = 0; i < n; i++) press(keys[4*(n-1-i) +: 4]);
      chk("pulse_early", {30'd0, unlock_ok, bad_pin}, 32'd0);
      @(negedge clk);
      chk("pulse_timing", {30'd0, unlock_ok, bad_pin}, {30'd0, ev});
      chk("locked_after_enter", {31'd0, locked}, (ev == EV_UNLOCK) ? 32'd0 : 32'd1);
   endtask

   task automatic relock_cmd();
      magnetic_sensor = 1'b1;
      lock_cmd        = 1'b1;
      @(negedge clk);
      chk("lock_cmd_closed", {31'd0, locked}, 32'd1);
      lock_cmd = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n           = 1'b1;
      key_valid       = 1'b0;
      key_code        = 4'h0;
      lock_cmd        = 1'b0;
      magnetic_sensor = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_locked", {31'd0, locked}, 32'd1);
      chk("rst_unlock_ok", {31'd0, unlock_ok}, 32'd0);
      chk("rst_bad_pin", {31'd0, bad_pin}, 32'd0);
      chk("rst_lockout", {31'd0, lockout}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Correct PIN, then auto-relock with the door held closed.
      enter_keys(32'h1234F, 5, EV_UNLOCK);
      edges = 0;
      for (int i = 0; i < 200 && locked !== 1'b1; i++) begin
         @(negedge clk);
         edges++;
      end
      chk("relock_edges", edges, 32'd32);

      // Three wrong entries -> lockout; keys ignored during lockout.
      for (int t = 0; t < 3; t++) begin
         enter_keys(32'h1235F, 5, EV_BAD);
         chk("lockout_after_bad", {31'd0, lockout}, (t == 2) ? 32'd1 : 32'd0);
      end
      enter_keys(32'h1234F, 5, EV_NONE);
      chk("lockout_holds", {31'd0, lockout}, 32'd1);
      edges = 11;
      for (int i = 0; i < 200 && lockout !== 1'b0; i++) begin
         @(negedge clk);
         edges++;
      end
      chk("lockout_len", edges, 32'd64);
      enter_keys(32'h1234F, 5, EV_UNLOCK);
      relock_cmd();

      // Open door: timer re-arms and lock_cmd is ignored.
      enter_keys(32'h1234F, 5, EV_UNLOCK);
      magnetic_sensor = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         lock_cmd = (i % 10 == 5);
         if (i == 50) chk("open_door_mid", {31'd0, locked}, 32'd0);
      end
      lock_cmd = 1'b0;
      @(negedge clk);
      chk("open_door_hold", {31'd0, locked}, 32'd0);
      relock_cmd();

      // Overflow entry is wrong; clear then correct PIN resets tries.
      enter_keys(32'h12345F, 6, EV_BAD);
      enter_keys(32'h9E1234F, 7, EV_UNLOCK);
      relock_cmd();
      enter_keys(32'h0000F, 1, EV_BAD);
      chk("tries_cleared_1", {31'd0, lockout}, 32'd0);
      enter_keys(32'h1243F, 5, EV_BAD);
      chk("tries_cleared_2", {31'd0, lockout}, 32'd0);
      enter_keys(32'h4321F, 5, EV_BAD);
      chk("third_bad_lockout", {31'd0, lockout}, 32'd1);

      // Asynchronous reset: from lockout, mid-entry, and while unlocked.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("arst_lockout", {31'd0, lockout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      press(4'h1);
      press(4'h2);
      #2 rst_n = 1'b0;
      #1 chk("arst_entry_locked", {31'd0, locked}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      enter_keys(32'h1234F, 5, EV_UNLOCK);
      #2 rst_n = 1'b0;
      #1 chk("arst_unlocked", {31'd0, locked}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      enter_keys(32'h5555F, 5, EV_BAD);
      enter_keys(32'h6666F, 5, EV_BAD);
      chk("arst_tries_cleared", {31'd0, lockout}, 32'd0);

      @(negedge clk);
      #1 chk("sb_drain", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
